// File: rtl/regbank_pkg.sv
// Shared encodings for the controller select bus and the responder FSM.
// Both ends of the select bus import this so the codes cannot drift apart.
package regbank_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 4;
   localparam int SEL_W  = 4;

   localparam logic [SEL_W-1:0] SRC_IMM = 4'd0;
   localparam logic [SEL_W-1:0] SRC_A   = 4'd1;
   localparam logic [SEL_W-1:0] SRC_B   = 4'd2;
   localparam logic [SEL_W-1:0] SRC_C   = 4'd3;
   localparam logic [SEL_W-1:0] SRC_MEM = 4'd4;
   localparam logic [SEL_W-1:0] SRC_ADD = 4'd5;
   localparam logic [SEL_W-1:0] SRC_SUB = 4'd6;
   localparam logic [SEL_W-1:0] SRC_AND = 4'd7;
   localparam logic [SEL_W-1:0] SRC_OR  = 4'd8;

   localparam logic [SEL_W-1:0] DST_NONE = 4'd0;
   localparam logic [SEL_W-1:0] DST_A    = 4'd1;
   localparam logic [SEL_W-1:0] DST_B    = 4'd2;
   localparam logic [SEL_W-1:0] DST_C    = 4'd3;
   localparam logic [SEL_W-1:0] DST_MEM  = 4'd4;
   localparam logic [SEL_W-1:0] DST_OUT  = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MEMRD = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   function automatic logic src_reserved(input logic [SEL_W-1:0] sel);
      return sel > SRC_OR;
   endfunction

   function automatic logic dst_reserved(input logic [SEL_W-1:0] sel);
      return sel > DST_OUT;
   endfunction

endpackage

// File: rtl/regbank_alu.sv
// Combinational op mux over the A/B operands for the ALU source codes.
// Results wrap modulo 2**DW; carry and borrow are dropped.
module regbank_alu
   import regbank_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [SEL_W-1:0] op,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   output logic [DW-1:0]    result
);

   always_comb begin
      result = '0;
      case (op)
         SRC_ADD: result = a + b;
         SRC_SUB: result = a - b;
         SRC_AND: result = a & b;
         SRC_OR:  result = a | b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/regbank_responder.sv
// Datapath responder: latches one transfer command per handshake, sources a
// value (imm/reg/mem/ALU) and writes it to A/B/C, scratch memory or OUT.
module regbank_responder
   import regbank_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [SEL_W-1:0] rd_sel,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [AW-1:0]    mar,
   input  logic [DW-1:0]    imm,
   output logic             ready,
   output logic             done,
   output logic             err,
   output logic             z,
   output logic [DW-1:0]    out,
   output logic [DW-1:0]    a,
   output logic [DW-1:0]    b,
   output logic [DW-1:0]    c
);

   state_t state_reg, state_next;

   logic [SEL_W-1:0] rd_sel_reg, wr_sel_reg;
   logic [AW-1:0]    mar_reg;
   logic [DW-1:0]    imm_reg;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] mem_rd_reg;
   logic [DW-1:0] out_reg;
   logic          z_reg, done_reg, err_reg;

   logic          accept, write_en, cmd_err;
   logic [DW-1:0] alu_result, src_value;
   logic [DW-1:0] gpr_value [3];

   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      accept     = 1'b0;
      write_en   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            ready = 1'b1;
            if (valid) begin
               accept     = 1'b1;
               state_next = (rd_sel == SRC_MEM) ? ST_MEMRD : ST_WRITE;
            end
         end
         ST_MEMRD: state_next = ST_WRITE;
         ST_WRITE: begin
            write_en   = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // The command is frozen at acceptance so the controller may move on.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_sel_reg <= '0;
         wr_sel_reg <= '0;
         mar_reg    <= '0;
         imm_reg    <= '0;
      end else if (accept) begin
         rd_sel_reg <= rd_sel;
         wr_sel_reg <= wr_sel;
         mar_reg    <= mar;
         imm_reg    <= imm;
      end
   end

   regbank_alu #(.DW(DW)) u_alu (
      .op     (rd_sel_reg),
      .a      (a),
      .b      (b),
      .result (alu_result)
   );

   always_comb begin
      src_value = '0;
      case (rd_sel_reg)
         SRC_IMM: src_value = imm_reg;
         SRC_A:   src_value = a;
         SRC_B:   src_value = b;
         SRC_C:   src_value = c;
         SRC_MEM: src_value = mem_rd_reg;
         SRC_ADD, SRC_SUB, SRC_AND, SRC_OR: src_value = alu_result;
         default: src_value = '0;
      endcase
   end

   assign cmd_err = src_reserved(rd_sel_reg) || dst_reserved(wr_sel_reg);

   // A, B and C occupy consecutive destination codes starting at 1.
   for (genvar gi = 0; gi < 3; gi++) begin : gen_gpr
      localparam logic [SEL_W-1:0] DST_CODE = SEL_W'(gi + 1);
      logic [DW-1:0] gpr_reg;

      always_ff @(posedge clk) begin
         if (reset) begin
            gpr_reg <= '0;
         end else if (write_en && wr_sel_reg == DST_CODE) begin
            gpr_reg <= src_value;
         end
      end

      assign gpr_value[gi] = gpr_reg;
   end

   assign a = gpr_value[0];
   assign b = gpr_value[1];
   assign c = gpr_value[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         out_reg  <= '0;
         z_reg    <= 1'b0;
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         done_reg <= write_en;
         err_reg  <= write_en && cmd_err;
         if (write_en) begin
            z_reg <= (src_value == '0);
         end
         if (write_en && wr_sel_reg == DST_OUT) begin
            out_reg <= src_value;
         end
      end
   end

   // Scratch memory keeps its contents across reset; only the write is gated.
   always_ff @(posedge clk) begin
      if (!reset && write_en && wr_sel_reg == DST_MEM) begin
         mem[mar_reg] <= src_value;
      end
      if (state_reg == ST_MEMRD) begin
         mem_rd_reg <= mem[mar_reg];
      end
   end

   assign out  = out_reg;
   assign z    = z_reg;
   assign done = done_reg;
   assign err  = err_reg;

endmodule
